// File: rtl/orv32s_mem_pkg.sv
// orv32s_mem_pkg: FSM states, legal byte-enable patterns and word-index helpers for the data RAM model.
package orv32s_mem_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, WR_WAIT = 2'd2} dram_state_e;
    localparam int BE_LEGAL_N = 7;
    localparam logic [3:0] BE_LEGAL [BE_LEGAL_N] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                                    4'b0011, 4'b1100, 4'b1111};
    function automatic logic [31:0] word_idx(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction
    function automatic logic be_legal(input logic [3:0] be);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < BE_LEGAL_N; i++) ok |= (be == BE_LEGAL[i]);
        return ok;
    endfunction
endpackage

// File: rtl/data_ram_be_merge.sv
// data_ram_be_merge: replaces the byte lanes of a stored word selected by a byte-enable mask.
module data_ram_be_merge (
    input  logic [31:0] old_i,
    input  logic [31:0] new_i,
    input  logic [3:0]  be_i,
    output logic [31:0] merged_o
);
    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign merged_o[8*g +: 8] = be_i[g] ? new_i[8*g +: 8] : old_i[8*g +: 8];
    end
endmodule

// File: rtl/data_ram_lat.sv
// data_ram_lat: data-side RAM model with fixed read/write response latency and a bench preload port.
// Define DATA_RAM_MISALIGN_CHK_EN to add err_o and byte-enable/alignment legality checks.
module data_ram_lat
    import orv32s_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          RD_LAT      = 2,
    parameter int          WR_LAT      = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [31:0]                    data_addr_i,
    input  logic [31:0]                    store_data_i,
    input  logic [3:0]                     byte_enable_i,
    input  logic                           MemR_en_i,
    input  logic                           MemW_en_i,
    output logic [31:0]                    load_data_o,
    output logic                           read_valid_o,
    output logic                           write_ready_o,
    output logic                           busy_o,
    input  logic                           preload_we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] preload_idx_i,
    input  logic [31:0]                    preload_data_i
`ifdef DATA_RAM_MISALIGN_CHK_EN
    ,
    output logic                           err_o
`endif
);
    localparam int AW      = $clog2(DEPTH_WORDS);
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    dram_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d, data_q, data_d, load_data_q, load_data_d;
    logic [3:0]    be_q, be_d;
    logic          read_valid_q, read_valid_d, write_ready_q, write_ready_d;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   idx, merged;
    logic [AW-1:0] widx;
    logic          in_range, bad, done, commit;

    assign idx      = word_idx(addr_q, BASE_ADDR);
    assign widx     = idx[AW-1:0];
    assign in_range = (addr_q >= BASE_ADDR) && (idx < 32'(DEPTH_WORDS));
    assign done     = (state_q != IDLE) && (cnt_q == '0);

`ifdef DATA_RAM_MISALIGN_CHK_EN
    logic err_q, err_d;
    // Reads can only fail on range; the lane/alignment rules apply to writes.
    assign bad = !in_range || ((state_q == WR_WAIT) && (!be_legal(be_q)
                 || (((be_q == 4'b0011) || (be_q == 4'b1100)) && addr_q[0])
                 || ((be_q == 4'b1111) && (addr_q[1:0] != 2'b00))));
    assign err_d = done && bad;
    assign err_o = err_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
`else
    assign bad = !in_range;
`endif

    assign commit = done && (state_q == WR_WAIT) && !bad;

    data_ram_be_merge u_merge (
        .old_i    (mem[widx]),
        .new_i    (data_q),
        .be_i     (be_q),
        .merged_o (merged)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        data_d        = data_q;
        be_d          = be_q;
        load_data_d   = load_data_q;
        read_valid_d  = 1'b0;
        write_ready_d = 1'b0;
        if (state_q == IDLE) begin
            if (MemW_en_i || MemR_en_i) begin
                state_d = MemW_en_i ? WR_WAIT : RD_WAIT;
                cnt_d   = MemW_en_i ? CW'(WR_LAT - 1) : CW'(RD_LAT - 1);
                addr_d  = data_addr_i;
                data_d  = store_data_i;
                be_d    = byte_enable_i;
            end
        end else if (done) begin
            state_d       = IDLE;
            read_valid_d  = (state_q == RD_WAIT);
            write_ready_d = (state_q == WR_WAIT);
            load_data_d   = (state_q == RD_WAIT) ? (in_range ? mem[widx] : 32'h0) : load_data_q;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            be_q          <= '0;
            load_data_q   <= '0;
            read_valid_q  <= 1'b0;
            write_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            be_q          <= be_d;
            load_data_q   <= load_data_d;
            read_valid_q  <= read_valid_d;
            write_ready_q <= write_ready_d;
        end
    end

    // Array is not reset; the core commit is last so it wins over a same-word preload.
    always_ff @(posedge clk) begin
        if (preload_we_i) mem[preload_idx_i] <= preload_data_i;
        if (commit)       mem[widx] <= merged;
    end

    assign load_data_o   = load_data_q;
    assign read_valid_o  = read_valid_q;
    assign write_ready_o = write_ready_q;
    assign busy_o        = (state_q != IDLE);
endmodule

// File: tb/tb_data_ram_lat.sv
// tb_data_ram_lat: directed vector bench for data_ram_lat (RD_LAT=2 instance plus an RD_LAT=3 instance for the reset case).
module tb_data_ram_lat;
`ifdef DATA_RAM_MISALIGN_CHK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic        mem_r = 1'b0, mem_w = 1'b0, pl_we = 1'b0;
    logic [11:0] pl_idx = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] ld_a, ld_b;
    logic        rv_a, wr_a, busy_a, rv_b, wr_b, busy_b;
    logic        err_a, err_b;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    data_ram_lat #(.RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) u_dut (
        .clk(clk), .rst(rst), .data_addr_i(addr), .store_data_i(wdata), .byte_enable_i(be),
        .MemR_en_i(mem_r), .MemW_en_i(mem_w), .load_data_o(ld_a), .read_valid_o(rv_a),
        .write_ready_o(wr_a), .busy_o(busy_a), .preload_we_i(pl_we), .preload_idx_i(pl_idx),
        .preload_data_i(pl_data)
`ifdef DATA_RAM_MISALIGN_CHK_EN
        , .err_o(err_a)
`endif
    );

    data_ram_lat #(.RD_LAT(3), .WR_LAT(WR_LAT)) u_dut3 (
        .clk(clk), .rst(rst), .data_addr_i(addr), .store_data_i(wdata), .byte_enable_i(be),
        .MemR_en_i(mem_r), .MemW_en_i(mem_w), .load_data_o(ld_b), .read_valid_o(rv_b),
        .write_ready_o(wr_b), .busy_o(busy_b), .preload_we_i(pl_we), .preload_idx_i(pl_idx),
        .preload_data_i(pl_data)
`ifdef DATA_RAM_MISALIGN_CHK_EN
        , .err_o(err_b)
`endif
    );

`ifndef DATA_RAM_MISALIGN_CHK_EN
    assign err_a = 1'b0;
    assign err_b = 1'b0;
`endif

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        return sel == 0 ? rv_a : sel == 1 ? wr_a : rv_b;
    endfunction

    // k=0 is the cycle right after the accept edge; the pulse should land at k=LAT.
    task automatic wait_pulse(input int sel, output int lat);
        lat = -1;
        for (int k = 0; k <= 20; k++) begin
            @(posedge clk); #1;
            if (sig(sel)) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic preload(input logic [11:0] idx, input logic [31:0] data);
        @(posedge clk); #1;
        pl_we = 1'b1; pl_idx = idx; pl_data = data;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    int          lat;
    logic [31:0] last_rd;

    initial begin
        vecs[0]  = '{"rd_idx5",      1'b0, 32'h14,   32'h0,        4'h0,    32'hDEAD_BEEF, 1'b0};
        vecs[1]  = '{"wr_be0010",    1'b1, 32'h0C,   32'h0000_AA00, 4'b0010, 32'h0,        1'b0};
        vecs[2]  = '{"rd_merge",     1'b0, 32'h0C,   32'h0,        4'h0,    32'h1122_AA44, 1'b0};
        vecs[3]  = '{"wr_word",      1'b1, 32'h30,   32'hCAFE_F00D, 4'b1111, 32'h0,        1'b0};
        vecs[4]  = '{"rd_word",      1'b0, 32'h30,   32'h0,        4'h0,    32'hCAFE_F00D, 1'b0};
        vecs[5]  = '{"rd_oor",       1'b0, 32'h4000, 32'h0,        4'h0,    32'h0,         CHK};
        vecs[6]  = '{"wr_oor",       1'b1, 32'h4000, 32'h1234_5678, 4'b1111, 32'h0,        CHK};
        vecs[7]  = '{"rd_lowbits",   1'b0, 32'h3,    32'h0,        4'h0,    32'hA5A5_A5A5, 1'b0};
        vecs[8]  = '{"wr_be0101",    1'b1, 32'h40,   32'hFFFF_FFFF, 4'b0101, 32'h0,        CHK};
        vecs[9]  = '{"rd_be0101",    1'b0, 32'h40,   32'h0,        4'h0,
                     CHK ? 32'h0102_0304 : 32'h01FF_03FF, 1'b0};
        vecs[10] = '{"wr_misword",   1'b1, 32'h49,   32'h9999_9999, 4'b1111, 32'h0,        CHK};
        vecs[11] = '{"rd_misword",   1'b0, 32'h48,   32'h0,        4'h0,
                     CHK ? 32'h1818_1818 : 32'h9999_9999, 1'b0};

        #1;
        chk("rst_load_data", ld_a, 32'h0);
        chk("rst_read_valid", {31'h0, rv_a}, 32'h0);
        chk("rst_write_ready", {31'h0, wr_a}, 32'h0);
        chk("rst_busy", {31'h0, busy_a}, 32'h0);
        chk("rst_err", {31'h0, err_a}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        preload(12'd5, 32'hDEAD_BEEF);
        preload(12'd3, 32'h1122_3344);
        preload(12'd0, 32'hA5A5_A5A5);
        preload(12'd16, 32'h0102_0304);
        preload(12'd18, 32'h1818_1818);
        last_rd = 32'h0;

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            addr = vecs[i].addr; wdata = vecs[i].data; be = vecs[i].be;
            mem_w = vecs[i].wr; mem_r = !vecs[i].wr;
            wait_pulse(vecs[i].wr ? 1 : 0, lat);
            chk({vecs[i].name, "_lat"}, 32'(lat), vecs[i].wr ? 32'(WR_LAT) : 32'(RD_LAT));
            if (vecs[i].wr) begin
                chk({vecs[i].name, "_hold"}, ld_a, last_rd);
            end else begin
                chk({vecs[i].name, "_data"}, ld_a, vecs[i].exp);
                last_rd = vecs[i].exp;
            end
            chk({vecs[i].name, "_err"}, {31'h0, err_a}, {31'h0, vecs[i].exp_err});
            mem_r = 1'b0; mem_w = 1'b0;
        end

        // Simultaneous read and write: write first, the held read follows.
        @(posedge clk); #1;
        addr = 32'h20; wdata = 32'h5; be = 4'b1111; mem_r = 1'b1; mem_w = 1'b1;
        wait_pulse(1, lat);
        chk("both_wr_lat", 32'(lat), 32'(WR_LAT));
        chk("both_no_rv", {31'h0, rv_a}, 32'h0);
        mem_w = 1'b0;
        wait_pulse(0, lat);
        chk("both_rd_lat", 32'(lat), 32'(RD_LAT));
        chk("both_rd_data", ld_a, 32'h5);
        mem_r = 1'b0;

        // Reset in the middle of an RD_LAT=3 read on the second instance.
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        preload(12'd7, 32'h7766_5544);
        @(posedge clk); #1;
        addr = 32'h1C; mem_r = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_busy_before", {31'h0, busy_b}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1; mem_r = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        wait_pulse(2, lat);
        chk("rst_mid_no_valid", 32'(lat), 32'hFFFF_FFFF);
        chk("rst_mid_busy", {31'h0, busy_b}, 32'h0);
        @(posedge clk); #1;
        addr = 32'h1C; mem_r = 1'b1;
        wait_pulse(2, lat);
        chk("rst_after_lat", 32'(lat), 32'd3);
        chk("rst_after_data", ld_b, 32'h7766_5544);
        mem_r = 1'b0;

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
